// File: rtl/ptw_resp_router.sv
// ptw_resp_router: in-order result buffer between the page-table walker
// write-back port and the L1 TLB refill ports. Each buffered walk result is
// steered to the TLB named by its source id; results whose source id names
// no TLB are silently discarded with a one-cycle drop_pulse.
//
// Optional build macro: PTW_RESP_BYPASS_EN
//   When defined, a result arriving at an empty buffer is presented to its
//   destination in the same cycle and skips the buffer if it is consumed
//   immediately. When undefined, every result is registered first.
module ptw_resp_router #(
  parameter int DEPTH   = 4,
  parameter int N_DEST  = 3,
  parameter int SRC_W   = 2,
  parameter int VADDR_W = 32,
  parameter int PTE_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_exception,
  input  logic [SRC_W-1:0]         in_src,
  input  logic [VADDR_W-1:0]       in_vaddr,
  input  logic [PTE_W-1:0]         in_entry,
  input  logic [1:0]               in_wpn,
  output logic [N_DEST-1:0]        out_valid,
  input  logic [N_DEST-1:0]        out_ready,
  output logic                     out_exception,
  output logic [VADDR_W-1:0]       out_vaddr,
  output logic [PTE_W-1:0]         out_entry,
  output logic [1:0]               out_wpn,
  output logic                     drop_pulse,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + SRC_W + VADDR_W + PTE_W + 2;

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [SRC_W:0]    N_DEST_X = (SRC_W + 1)'(N_DEST);
  localparam logic [N_DEST-1:0] ONE_HOT0 = N_DEST'(1);

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [CNT_W-1:0]   count;

  logic               head_exc;
  logic [SRC_W-1:0]   head_src;
  logic [VADDR_W-1:0] head_vaddr;
  logic [PTE_W-1:0]   head_entry;
  logic [1:0]         head_wpn;

  logic               empty;
  logic               head_legal;
  logic               in_legal;
  logic               push;
  logic               wr_en;
  logic               pop;

  assign {head_exc, head_src, head_vaddr, head_entry, head_wpn} = mem[rptr];

  assign empty      = (count == '0);
  assign head_legal = ({1'b0, head_src} < N_DEST_X);
  assign in_legal   = ({1'b0, in_src} < N_DEST_X);

  // A full buffer refuses input even if the head leaves this cycle; keeps the ready path free of out_ready.
  assign in_ready  = (count != FULL_CNT) & ~flush;
  assign push      = in_valid & in_ready;
  assign occupancy = count;

  // Head routing, illegal-source discard and (optionally) empty-buffer bypass.
  always_comb begin
    out_valid     = '0;
    out_exception = head_exc;
    out_vaddr     = head_vaddr;
    out_entry     = head_entry;
    out_wpn       = head_wpn;
    drop_pulse    = 1'b0;
    wr_en         = push;
    if (!flush && !empty) begin
      if (head_legal) begin
        out_valid = ONE_HOT0 << head_src;
      end else begin
        drop_pulse = 1'b1;
      end
    end
`ifdef PTW_RESP_BYPASS_EN
    else if (!flush && in_valid && in_legal) begin
      out_valid     = ONE_HOT0 << in_src;
      out_exception = in_exception;
      out_vaddr     = in_vaddr;
      out_entry     = in_entry;
      out_wpn       = in_wpn;
      // Consumed on the spot, so it never occupies a slot.
      if ((out_valid & out_ready) != '0) begin
        wr_en = 1'b0;
      end
    end
`endif
  end

  // A bypassed result never pops: pop only applies to an occupied buffer.
  assign pop = !flush && !empty && (drop_pulse || ((out_valid & out_ready) != '0));

  // Entry storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= {in_exception, in_src, in_vaddr, in_entry, in_wpn};
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_W'(1);
      if (pop)   rptr <= rptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // in_legal is only consumed by the bypass path.
  logic unused_in_legal;
  assign unused_in_legal = in_legal;

endmodule
